// File: rtl/fifo_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_ctrl
//
// Purpose:
//   Control and storage stage of an 8-entry, 32-bit FIFO. Each rising edge
//   it decides one operation from the sampled write/read requests and the
//   current occupancy. It then updates the head/tail pointers, the storage
//   array, the occupancy count and the registered read data. The registered
//   operation code and occupancy feed the downstream flag decoder (fifo_out).
//
// Ports:
//   clk         in   1      sole clock, all state changes on the rising edge
//   reset       in   1      synchronous, active-high reset
//   wr_en       in   1      write request, sampled each rising edge
//   rd_en       in   1      read request, sampled each rising edge
//   din         in   WIDTH  write data, sampled together with wr_en
//   state       out  3      registered code of the operation just performed
//   data_count  out  4      registered post-operation occupancy, 0..DEPTH
//   dout        out  WIDTH  registered read data, updated only on READ
//
// Operation codes:
//   INIT=000  WRITE=001  READ=010  WR_ERROR=101  RD_ERROR=110  NO_OP=111
//   The codes 011 and 100 are never produced.
// ---------------------------------------------------------------------------
module fifo_ctrl #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] din,
    output logic [2:0]       state,
    output logic [3:0]       data_count,
    output logic [WIDTH-1:0] dout
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [2:0] ST_INIT     = 3'b000;
    localparam logic [2:0] ST_WRITE    = 3'b001;
    localparam logic [2:0] ST_READ     = 3'b010;
    localparam logic [2:0] ST_WR_ERROR = 3'b101;
    localparam logic [2:0] ST_RD_ERROR = 3'b110;
    localparam logic [2:0] ST_NO_OP    = 3'b111;

    localparam logic [3:0] COUNT_FULL  = 4'(DEPTH);
    localparam logic [3:0] COUNT_EMPTY = 4'd0;

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [PTR_W-1:0] r_headPtr;
    logic [PTR_W-1:0] r_tailPtr;
    logic [3:0]       r_count;
    logic [2:0]       r_state;
    logic [WIDTH-1:0] r_dout;

    logic [2:0]       w_nextState;
    logic             w_doWrite;
    logic             w_doRead;
    logic             w_isFull;
    logic             w_isEmpty;

    // Occupancy-derived conditions used by the request arbitration below.
    assign w_isFull  = (r_count == COUNT_FULL);
    assign w_isEmpty = (r_count == COUNT_EMPTY);

    // Request arbitration. A lone write or a lone read is performed if the
    // occupancy allows it and is otherwise reported as an error. Simultaneous
    // requests, or no request at all, are treated as a single no-op and never
    // as an error. The decision depends only on the sampled requests and on
    // the registered occupancy, so at most one of doWrite/doRead is ever set.
    always_comb begin
        w_nextState = ST_NO_OP;
        w_doWrite   = 1'b0;
        w_doRead    = 1'b0;
        if (wr_en && !rd_en) begin
            if (w_isFull) begin
                w_nextState = ST_WR_ERROR;
            end else begin
                w_nextState = ST_WRITE;
                w_doWrite   = 1'b1;
            end
        end else if (rd_en && !wr_en) begin
            if (w_isEmpty) begin
                w_nextState = ST_RD_ERROR;
            end else begin
                w_nextState = ST_READ;
                w_doRead    = 1'b1;
            end
        end
    end

    // Storage array. It has no reset: contents are only meaningful between
    // the pointers, and leaving it unreset keeps it mappable to plain RAM.
    // A reset edge suppresses the write so a request that arrives together
    // with reset is discarded as a whole.
    always_ff @(posedge clk) begin
        if (!reset && w_doWrite) begin
            r_mem[r_tailPtr] <= din;
        end
    end

    // Control registers: operation code, pointers, occupancy and read data.
    // The pointers are exactly PTR_W bits wide, so incrementing past the last
    // entry wraps to entry 0 without any extra compare. The read data register
    // is loaded only by a successful read and holds its value otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_INIT;
            r_count   <= COUNT_EMPTY;
            r_headPtr <= '0;
            r_tailPtr <= '0;
            r_dout    <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_doWrite) begin
                r_tailPtr <= r_tailPtr + PTR_W'(1);
                r_count   <= r_count + 4'd1;
            end
            if (w_doRead) begin
                r_dout    <= r_mem[r_headPtr];
                r_headPtr <= r_headPtr + PTR_W'(1);
                r_count   <= r_count - 4'd1;
            end
        end
    end

    assign state      = r_state;
    assign data_count = r_count;
    assign dout       = r_dout;

endmodule

// File: tb/tb_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_ctrl
//
// Purpose:
//   Self-checking bench for fifo_ctrl. Every edge is driven through
//   applyStimulus. That task also advances a queue-based reference model of
//   the FIFO and then compares state, data_count and dout after the edge.
//   Directed steps cover reset, fill, overflow, drain, underflow, pointer
//   wrap, simultaneous requests and reset during a write. A random phase
//   follows them.
// ---------------------------------------------------------------------------
module tb_fifo_ctrl;

    localparam logic [2:0] INIT     = 3'b000;
    localparam logic [2:0] WRITE    = 3'b001;
    localparam logic [2:0] READ     = 3'b010;
    localparam logic [2:0] WR_ERROR = 3'b101;
    localparam logic [2:0] RD_ERROR = 3'b110;
    localparam logic [2:0] NO_OP    = 3'b111;

    logic        clk;
    logic        reset;
    logic        wrEn;
    logic        rdEn;
    logic [31:0] din;
    logic [2:0]  stateOut;
    logic [3:0]  countOut;
    logic [31:0] doutOut;

    logic [31:0] modelQueue [$];
    logic [2:0]  expState;
    logic [31:0] expDout;
    logic [3:0]  expCount;

    int errors;
    int checks;

    fifo_ctrl #(.DEPTH(8), .WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wrEn),
        .rd_en      (rdEn),
        .din        (din),
        .state      (stateOut),
        .data_count (countOut),
        .dout       (doutOut)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compares the three DUT outputs against the model's expectations.
    task automatic checkOutput(input string tag);
        checks++;
        assert (stateOut === expState) else begin
            errors++;
            $error("FAIL %s state: observed=%b expected=%b", tag, stateOut, expState);
        end
        checks++;
        assert (countOut === expCount) else begin
            errors++;
            $error("FAIL %s data_count: observed=%0d expected=%0d", tag, countOut, expCount);
        end
        checks++;
        assert (doutOut === expDout) else begin
            errors++;
            $error("FAIL %s dout: observed=%h expected=%h", tag, doutOut, expDout);
        end
    endtask

    // Drives one edge's worth of inputs, advances the reference model by
    // the same edge, then samples the DUT 1 unit after the rising edge.
    task automatic applyStimulus(input logic rst, input logic w, input logic r,
                                 input logic [31:0] d, input string tag);
        reset = rst;
        wrEn  = w;
        rdEn  = r;
        din   = d;
        @(posedge clk);
        if (rst) begin
            modelQueue.delete();
            expState = INIT;
            expDout  = '0;
        end else if (w && !r) begin
            if (modelQueue.size() < 8) begin
                modelQueue.push_back(d);
                expState = WRITE;
            end else begin
                expState = WR_ERROR;
            end
        end else if (r && !w) begin
            if (modelQueue.size() > 0) begin
                expDout  = modelQueue.pop_front();
                expState = READ;
            end else begin
                expState = RD_ERROR;
            end
        end else begin
            expState = NO_OP;
        end
        expCount = 4'(modelQueue.size());
        #1;
        checkOutput(tag);
    endtask

    initial begin
        logic        w;
        logic        r;
        logic        rst;
        logic [31:0] d;
        errors   = 0;
        checks   = 0;
        reset    = 1'b1;
        wrEn     = 1'b0;
        rdEn     = 1'b0;
        din      = '0;
        expState = INIT;
        expCount = '0;
        expDout  = '0;

        @(posedge clk);
        #1;
        $display("[TB] reset and idle");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, "reset");
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, "idle");

        $display("[TB] fill and overflow");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'hA0 + 32'(i), "fill");
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 32'hFF, "overflow");

        $display("[TB] drain and underflow");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, "drain");
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, "underflow");

        $display("[TB] pointer wrap");
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h100 + 32'(i), "wrapWrite5");
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, "wrapRead5");
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h200 + 32'(i), "wrapWrite6");
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, "wrapRead6");

        $display("[TB] simultaneous requests");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h300 + 32'(i), "preBoth");
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hDEAD, "bothReq");

        $display("[TB] reset during write");
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h400 + 32'(i), "preReset");
        applyStimulus(1'b1, 1'b1, 1'b0, 32'hBEEF, "resetWrite");
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, "readAfterReset");

        $display("[TB] random phase");
        for (int i = 0; i < 400; i++) begin
            w   = 1'($urandom_range(0, 1));
            r   = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 59) == 0);
            d   = $urandom;
            applyStimulus(rst, w, r, d, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
